biquad_pole_iir_mc: RTL and testbench
=====================================

// Module: biquad_pole_iir_mc
// PURPOSE
//  Multi-channel, 2-samples-per-clock pole (recursive) section of the biquad filter.
//  Per channel: [y0;y1](n) = [A B;C D]*[y0;y1](n-1) + [x0;x1](n).
//  Double-buffered (shadow/active) coefficient banks; atomic update.
//  Sits after the zero (FIR) section, before output requantisation.
// PARAMETERS
//  NCH    2    independent channels
//  NBITS  24   sample width, signed, same Q-format for x and y
//  NFRAC  10   fractional bits of x/y (informational; arithmetic is format-agnostic)
//  CFRAC  14   fractional bits of 18-bit signed coefficients
// PORTS
//  clk             in   1         clock
//  rst             in   1         async active-high reset
//  coeff_dat_i     in   18        coefficient write data, signed Q3.14
//  coeff_wr_i      in   1         write coeff_dat_i to shadow[ptr], ptr++
//  coeff_update_i  in   1         copy shadow bank to active bank, ptr<=0
//  coeff_ptr_o     out  clog2(4*NCH)  current shadow write pointer
//  in_valid_i      in   1         x inputs valid; state advances only when high
//  x0_i            in   NCH*NBITS even-sample FIR outputs, ch0 in LSBs
//  x1_i            in   NCH*NBITS odd-sample FIR outputs
//  out_valid_o     out  1         y outputs valid
//  y0_o            out  NCH*NBITS even-sample outputs
//  y1_o            out  NCH*NBITS odd-sample outputs
//  ovf_o           out  NCH       sticky per-channel overflow flag
//  ovf_clr_i       in   1         clear all ovf_o bits
// BEHAVIOUR
//  - Reset: all state, y0_o, y1_o, out_valid_o, ovf_o, coeff_ptr_o = 0; both banks = 0.
//  - Shadow order: ch0 A,B,C,D, ch1 A,B,C,D, ...; ptr wraps 4*NCH-1 -> 0.
//  - wr and update same cycle: write lands in shadow first; active receives the
//    shadow including that word; ptr then = 0.
//  - New active coefficients apply from the first in_valid_i cycle after the update edge.
//  - Recursion, per channel, on in_valid_i: acc0 = (x0<<<CFRAC) + A*y0s + B*y1s;
//    acc1 = (x1<<<CFRAC) + C*y0s + D*y1s. Acc width NBITS+20, no internal overflow.
//  - Result = acc>>>CFRAC (arithmetic shift, truncation toward -inf), then limit to NBITS.
//  - y0s/y1s state registers update in one clock (loop latency 1); in_valid_i low holds state.
//  - Output registered: y0_o/y1_o = state one clock later; out_valid_o = in_valid_i delayed 2.
//  - Overflow: ovf_o[c] sets when either result of channel c exceeds NBITS range;
//    set and ovf_clr_i in the same cycle -> bit stays set.
// CONFIGURATION
//  - BIQUAD_POLE_SAT_EN defined: out-of-range results clamp to +max / -min; the clamped
//    value is both output and fed back.
//  - Not defined: results wrap (two's complement, low NBITS kept); ovf_o still reports.
// STRUCTURE
//  - Package biquad_pkg: COEF_A=0, COEF_B=1, COEF_C=2, COEF_D=3, NCOEF=4, coefficient
//    width 18, sat/wrap limit function.
//  - Sub-module biquad_pole_iir_ch: one channel's state, math, limiting, ovf flag;
//    top owns coefficient banks, ptr, valid pipe; generate-loop over NCH.
// TESTING
//  1 Impulse: NCH=2, ch0 A=D=0.5 (8192), B=C=0; x0=1000 one cycle -> y0: 1000,500,250,...
//    y1 stays 0; ch1 coefficients 0 -> ch1 output equals input.
//  2 Bank swap: load 8 words, no update -> response unchanged; pulse update -> new coeffs
//    take effect on next valid sample; coeff_ptr_o == 0 after update.
//  3 Write+update same cycle at ptr=7 -> word 7 present in active bank; ptr=0.
//  4 Saturation: A=1.0 (16384), x0=+2^22 each valid cycle -> with BIQUAD_POLE_SAT_EN y0
//    clamps at 2^23-1, ovf_o[0]=1; without, y0 wraps negative, ovf_o[0]=1.
//  5 Valid gaps: in_valid_i toggles 1,0,0,1 -> state holds during gaps; out_valid_o
//    follows input by 2 clocks; output matches gap-free golden model.
//  6 Async rst mid-stream with nonzero state -> all outputs/state/banks 0 immediately;
//    ovf_clr_i and ovf set coincident -> flag stays 1.

Source files
------------

// File: rtl/biquad_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : biquad_pkg
//  Description : Shared constants and helpers for the biquad pole section.
//                Coefficient word indices within a channel's group of four,
//                coefficient width, and the result limiting / range-check
//                functions (saturate or two's-complement wrap).
//                Limiting behaviour is selected by the caller; the
//                BIQUAD_POLE_SAT_EN macro is resolved in biquad_pole_iir_ch.
//  Revision    : 1.0 - initial release
// ============================================================================
package biquad_pkg;

   localparam int COEF_A = 0;
   localparam int COEF_B = 1;
   localparam int COEF_C = 2;
   localparam int COEF_D = 3;
   localparam int NCOEF  = 4;
   localparam int CWIDTH = 18;

   // Working width for the limit helpers; wide enough for any accumulator
   // result of a 24..44 bit datapath.
   localparam int LIMW   = 64;

   typedef logic signed [CWIDTH-1:0] coef_t;

   // Bring v into the signed nbits range: clamp when sat_en, otherwise keep
   // the low nbits and sign-extend them (two's-complement wrap).
   function automatic logic signed [LIMW-1:0] limit_fn(
      input logic signed [LIMW-1:0] v,
      input int                     nbits,
      input logic                   sat_en
   );
      logic signed [LIMW-1:0] hi;
      logic signed [LIMW-1:0] lo;
      hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (!sat_en)
         limit_fn = (v <<< (LIMW - nbits)) >>> (LIMW - nbits);
      else if (v > hi)
         limit_fn = hi;
      else if (v < lo)
         limit_fn = lo;
      else
         limit_fn = v;
   endfunction

   function automatic logic out_of_range(
      input logic signed [LIMW-1:0] v,
      input int                     nbits
   );
      logic signed [LIMW-1:0] hi;
      logic signed [LIMW-1:0] lo;
      hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      out_of_range = (v > hi) || (v < lo);
   endfunction

endpackage : biquad_pkg
`default_nettype wire

// File: rtl/biquad_pole_iir_ch.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_pole_iir_ch
//  Description : One channel of the 2-samples-per-clock pole section.
//                  [y0;y1](n) = [A B;C D] * [y0;y1](n-1) + [x0;x1](n)
//                State advances only when i_en is high (loop latency 1);
//                outputs are the state registered once more.
//                Macro BIQUAD_POLE_SAT_EN: defined -> clamp out-of-range
//                results (clamped value is also fed back); undefined -> wrap.
//                Sticky overflow flag, set has priority over clear.
//  Ports       : clk, rst        clock, async active-high reset
//                i_en            sample valid, advances the recursion
//                i_x0, i_x1      even/odd input samples (signed NBITS)
//                i_ca..i_cd      active coefficients A,B,C,D (signed Q3.14)
//                i_ovf_clr       clear sticky overflow
//                o_y0, o_y1      registered even/odd outputs
//                o_ovf           sticky overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad_pole_iir_ch
   import biquad_pkg::*;
#(
   parameter int NBITS = 24,
   parameter int CFRAC = 14
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_en,
   input  logic signed [NBITS-1:0] i_x0,
   input  logic signed [NBITS-1:0] i_x1,
   input  coef_t                   i_ca,
   input  coef_t                   i_cb,
   input  coef_t                   i_cc,
   input  coef_t                   i_cd,
   input  logic                    i_ovf_clr,
   output logic signed [NBITS-1:0] o_y0,
   output logic signed [NBITS-1:0] o_y1,
   output logic                    o_ovf
);

   // Two NBITS x 18 products plus the aligned input never exceed NBITS+20.
   localparam int ACCW = NBITS + 20;

`ifdef BIQUAD_POLE_SAT_EN
   localparam logic c_SAT_EN = 1'b1;
`else
   localparam logic c_SAT_EN = 1'b0;
`endif

   logic signed [NBITS-1:0] r_y0s;
   logic signed [NBITS-1:0] r_y1s;
   logic signed [NBITS-1:0] r_y0o;
   logic signed [NBITS-1:0] r_y1o;
   logic                    r_ovf;

   logic signed [ACCW-1:0]  w_acc0;
   logic signed [ACCW-1:0]  w_acc1;
   logic signed [ACCW-1:0]  w_res0;
   logic signed [ACCW-1:0]  w_res1;
   logic signed [NBITS-1:0] w_y0n;
   logic signed [NBITS-1:0] w_y1n;
   logic                    w_ovf0;
   logic                    w_ovf1;

   // Operands are sign-extended to ACCW before multiplying so each product
   // is computed at full accumulator width.
   assign w_acc0 = (ACCW'(i_x0) <<< CFRAC)
                 + ACCW'(i_ca) * ACCW'(r_y0s)
                 + ACCW'(i_cb) * ACCW'(r_y1s);
   assign w_acc1 = (ACCW'(i_x1) <<< CFRAC)
                 + ACCW'(i_cc) * ACCW'(r_y0s)
                 + ACCW'(i_cd) * ACCW'(r_y1s);

   // Arithmetic shift: truncation toward -inf.
   assign w_res0 = w_acc0 >>> CFRAC;
   assign w_res1 = w_acc1 >>> CFRAC;

   assign w_y0n  = NBITS'(limit_fn(LIMW'(w_res0), NBITS, c_SAT_EN));
   assign w_y1n  = NBITS'(limit_fn(LIMW'(w_res1), NBITS, c_SAT_EN));
   assign w_ovf0 = out_of_range(LIMW'(w_res0), NBITS);
   assign w_ovf1 = out_of_range(LIMW'(w_res1), NBITS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y0s <= '0;
         r_y1s <= '0;
         r_y0o <= '0;
         r_y1o <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (i_en) begin
            r_y0s <= w_y0n;
            r_y1s <= w_y1n;
         end
         r_y0o <= r_y0s;
         r_y1o <= r_y1s;
         // A new overflow in the clearing cycle keeps the flag set.
         r_ovf <= (r_ovf & ~i_ovf_clr) | (i_en & (w_ovf0 | w_ovf1));
      end
   end

   assign o_y0  = r_y0o;
   assign o_y1  = r_y1o;
   assign o_ovf = r_ovf;

endmodule : biquad_pole_iir_ch
`default_nettype wire

// File: rtl/biquad_pole_iir_mc.sv
`default_nettype none
// ============================================================================
//  Module      : biquad_pole_iir_mc
//  Description : Multi-channel, 2-samples-per-clock pole (recursive) section
//                of the biquad. Owns the double-buffered coefficient banks
//                (shadow written word by word, copied atomically to active),
//                the shadow write pointer and the 2-stage valid pipe;
//                instantiates one biquad_pole_iir_ch per channel.
//                Macro BIQUAD_POLE_SAT_EN: saturating results (see channel).
//  Ports       : clk, rst          clock, async active-high reset
//                coeff_dat_i       coefficient word, signed Q3.14
//                coeff_wr_i        write word to shadow[ptr], ptr++ (wraps)
//                coeff_update_i    shadow -> active, ptr <= 0
//                coeff_ptr_o       current shadow write pointer
//                in_valid_i        x inputs valid
//                x0_i, x1_i        even/odd inputs, ch0 in LSBs
//                out_valid_o       y outputs valid (in_valid_i delayed 2)
//                y0_o, y1_o        even/odd outputs, ch0 in LSBs
//                ovf_o             sticky per-channel overflow
//                ovf_clr_i         clear all overflow flags
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad_pole_iir_mc
   import biquad_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int NBITS = 24,
   parameter int NFRAC = 10,
   parameter int CFRAC = 14
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic signed [CWIDTH-1:0]       coeff_dat_i,
   input  logic                           coeff_wr_i,
   input  logic                           coeff_update_i,
   output logic [$clog2(NCOEF*NCH)-1:0]   coeff_ptr_o,
   input  logic                           in_valid_i,
   input  logic [NCH*NBITS-1:0]           x0_i,
   input  logic [NCH*NBITS-1:0]           x1_i,
   output logic                           out_valid_o,
   output logic [NCH*NBITS-1:0]           y0_o,
   output logic [NCH*NBITS-1:0]           y1_o,
   output logic [NCH-1:0]                 ovf_o,
   input  logic                           ovf_clr_i
);

   localparam int NWORD = NCOEF * NCH;
   localparam int PTRW  = $clog2(NWORD);

   coef_t           r_shadow [NWORD];
   coef_t           r_active [NWORD];
   coef_t           w_shadow_nxt [NWORD];
   logic [PTRW-1:0] r_ptr;
   logic            r_vld_d1;
   logic            r_vld_d2;

   // NFRAC only documents the sample Q-format; the datapath is
   // format-agnostic. A fractional part wider than the sample is a
   // configuration error and elaborates to nothing useful.
   if (NFRAC > NBITS) begin : g_nfrac_exceeds_nbits
   end

   // Shadow contents after this cycle's write, so an update in the same
   // cycle copies the word being written as well.
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (coeff_wr_i)
         w_shadow_nxt[r_ptr] = coeff_dat_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow <= '{default: '0};
         r_active <= '{default: '0};
         r_ptr    <= '0;
      end else begin
         r_shadow <= w_shadow_nxt;
         if (coeff_update_i) begin
            r_active <= w_shadow_nxt;
            r_ptr    <= '0;
         end else if (coeff_wr_i) begin
            r_ptr    <= (r_ptr == PTRW'(NWORD - 1)) ? '0 : r_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_d1 <= 1'b0;
         r_vld_d2 <= 1'b0;
      end else begin
         r_vld_d1 <= in_valid_i;
         r_vld_d2 <= r_vld_d1;
      end
   end

   assign coeff_ptr_o = r_ptr;
   assign out_valid_o = r_vld_d2;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      biquad_pole_iir_ch #(
         .NBITS (NBITS),
         .CFRAC (CFRAC)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_en      (in_valid_i),
         .i_x0      (x0_i[c*NBITS +: NBITS]),
         .i_x1      (x1_i[c*NBITS +: NBITS]),
         .i_ca      (r_active[c*NCOEF + COEF_A]),
         .i_cb      (r_active[c*NCOEF + COEF_B]),
         .i_cc      (r_active[c*NCOEF + COEF_C]),
         .i_cd      (r_active[c*NCOEF + COEF_D]),
         .i_ovf_clr (ovf_clr_i),
         .o_y0      (y0_o[c*NBITS +: NBITS]),
         .o_y1      (y1_o[c*NBITS +: NBITS]),
         .o_ovf     (ovf_o[c])
      );
   end

endmodule : biquad_pole_iir_mc
`default_nettype wire

// File: tb/tb_biquad_pole_iir_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_biquad_pole_iir_mc
//  Description : Self-checking bench for biquad_pole_iir_mc (NCH=2, NBITS=24).
//                Behavioural model of the coefficient banks and recursion;
//                expected outputs are queued when a valid sample is driven
//                and compared when out_valid_o is seen. Honours
//                BIQUAD_POLE_SAT_EN for the expected limiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_biquad_pole_iir_mc;

   localparam int     NCH   = 2;
   localparam int     NBITS = 24;
   localparam int     NW    = 4 * NCH;
   localparam longint YMAX  = (64'sd1 <<< (NBITS - 1)) - 64'sd1;
   localparam longint YMIN  = -YMAX - 64'sd1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic signed [17:0]    coeff_dat_i;
   logic                  coeff_wr_i;
   logic                  coeff_update_i;
   logic [2:0]            coeff_ptr_o;
   logic                  in_valid_i;
   logic [NCH*NBITS-1:0]  x0_i;
   logic [NCH*NBITS-1:0]  x1_i;
   logic                  out_valid_o;
   logic [NCH*NBITS-1:0]  y0_o;
   logic [NCH*NBITS-1:0]  y1_o;
   logic [NCH-1:0]        ovf_o;
   logic                  ovf_clr_i;

   biquad_pole_iir_mc #(.NCH(NCH), .NBITS(NBITS), .NFRAC(10), .CFRAC(14)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .coeff_dat_i    (coeff_dat_i),
      .coeff_wr_i     (coeff_wr_i),
      .coeff_update_i (coeff_update_i),
      .coeff_ptr_o    (coeff_ptr_o),
      .in_valid_i     (in_valid_i),
      .x0_i           (x0_i),
      .x1_i           (x1_i),
      .out_valid_o    (out_valid_o),
      .y0_o           (y0_o),
      .y1_o           (y1_o),
      .ovf_o          (ovf_o),
      .ovf_clr_i      (ovf_clr_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH*NBITS-1:0] y0;
      logic [NCH*NBITS-1:0] y1;
   } exp_t;

   exp_t           sb[$];
   int             n_checks = 0;
   int             n_errors = 0;

   longint         m_y0 [NCH];
   longint         m_y1 [NCH];
   longint         m_act [NW];
   longint         m_shd [NW];
   int             m_ptr;
   logic [NCH-1:0] m_ovf;
   logic           vd1, vd2;
   longint         sx0 [NCH];
   longint         sx1 [NCH];
   longint         words [NW];

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_lim(input longint r, output longint y, output logic of);
      longint w;
      of = (r > YMAX) || (r < YMIN);
`ifdef BIQUAD_POLE_SAT_EN
      y = (r > YMAX) ? YMAX : (r < YMIN) ? YMIN : r;
`else
      w = r & longint'(64'hFF_FFFF);
      y = (w > YMAX) ? w - (64'sd1 <<< NBITS) : w;
`endif
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin m_y0[c] = 0; m_y1[c] = 0; end
      for (int i = 0; i < NW; i++) begin m_act[i] = 0; m_shd[i] = 0; end
      m_ptr = 0; m_ovf = '0; vd1 = 1'b0; vd2 = 1'b0;
      sb.delete();
   endtask

   // One clock: observe outputs, then drive inputs and advance the model.
   task automatic step(input logic v, input logic wr, input longint dat,
                       input logic upd, input logic clr);
      exp_t           e;
      logic [NCH-1:0] setb;
      longint         r0, r1, n0, n1;
      logic           of0, of1;
      @(negedge clk);
      check("out_valid", longint'(out_valid_o), longint'(vd2));
      check("coeff_ptr", longint'(coeff_ptr_o), longint'(m_ptr));
      check("ovf", longint'(ovf_o), longint'(m_ovf));
      if (out_valid_o) begin
         check("sb_nonempty", longint'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int c = 0; c < NCH; c++) begin
               check($sformatf("y0_ch%0d", c), longint'($signed(y0_o[c*NBITS +: NBITS])),
                     longint'($signed(e.y0[c*NBITS +: NBITS])));
               check($sformatf("y1_ch%0d", c), longint'($signed(y1_o[c*NBITS +: NBITS])),
                     longint'($signed(e.y1[c*NBITS +: NBITS])));
            end
         end
      end
      in_valid_i     = v;
      coeff_wr_i     = wr;
      coeff_dat_i    = dat[17:0];
      coeff_update_i = upd;
      ovf_clr_i      = clr;
      for (int c = 0; c < NCH; c++) begin
         x0_i[c*NBITS +: NBITS] = sx0[c][NBITS-1:0];
         x1_i[c*NBITS +: NBITS] = sx1[c][NBITS-1:0];
      end
      vd2 = vd1; vd1 = v;
      setb = '0;
      if (v) begin
         for (int c = 0; c < NCH; c++) begin
            r0 = ((sx0[c] <<< 14) + m_act[4*c+0] * m_y0[c] + m_act[4*c+1] * m_y1[c]) >>> 14;
            r1 = ((sx1[c] <<< 14) + m_act[4*c+2] * m_y0[c] + m_act[4*c+3] * m_y1[c]) >>> 14;
            model_lim(r0, n0, of0);
            model_lim(r1, n1, of1);
            m_y0[c] = n0; m_y1[c] = n1;
            setb[c] = of0 | of1;
            e.y0[c*NBITS +: NBITS] = n0[NBITS-1:0];
            e.y1[c*NBITS +: NBITS] = n1[NBITS-1:0];
         end
         sb.push_back(e);
      end
      m_ovf = (m_ovf & ~{NCH{clr}}) | setb;
      if (wr) m_shd[m_ptr] = dat;
      if (upd) begin
         m_act = m_shd;
         m_ptr = 0;
      end else if (wr) begin
         m_ptr = (m_ptr + 1) % NW;
      end
   endtask

   task automatic set_x(input longint a0, input longint a1, input longint b0, input longint b1);
      sx0[0] = a0; sx1[0] = a1; sx0[1] = b0; sx1[1] = b1;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, words[i], 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      set_x(0, 0, 0, 0);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      coeff_dat_i = '0; coeff_wr_i = 1'b0; coeff_update_i = 1'b0;
      in_valid_i = 1'b0; x0_i = '0; x1_i = '0; ovf_clr_i = 1'b0;
      model_reset();
      set_x(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("rst_y0", longint'(y0_o), 0);
      check("rst_y1", longint'(y1_o), 0);
      check("rst_valid", longint'(out_valid_o), 0);
      check("rst_ovf", longint'(ovf_o), 0);
      check("rst_ptr", longint'(coeff_ptr_o), 0);
      rst = 1'b0;

      // Impulse: ch0 A=D=0.5, ch1 all zero (pass-through).
      words = '{8192, 0, 0, 8192, 0, 0, 0, 0};
      load_words(NW);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      set_x(1000, 0, 77, -5);
      step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      set_x(0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      idle(3);

      // Bank swap: load new shadow, responses keep old coefficients until
      // update; update shares a cycle with a valid sample.
      words = '{4096, 2048, -3000, 6000, -8192, 1000, 500, 12000};
      load_words(NW);
      for (int i = 0; i < 3; i++) begin
         set_x(300 * (i + 1), -200, 1000 - i, 45);
         step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      end
      set_x(5000, 1234, -777, 2222);
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_x(-1000 + 500 * i, 800, 64 * i, -300);
         step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      end

      // Write + update in the same cycle at ptr=7.
      words = '{4096, 2048, -3000, 6000, -8192, 1000, 500, -9000};
      load_words(NW - 1);
      step(1'b0, 1'b1, words[NW-1], 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_x(100, 200 * i, 3000, -4000 + i);
         step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      end

      // Valid gaps 1,0,0,1 with random stimulus.
      for (int k = 0; k < 12; k++) begin
         set_x(longint'($urandom_range(0, 400000)) - 200000, longint'($urandom_range(0, 400000)) - 200000,
               longint'($urandom_range(0, 400000)) - 200000, longint'($urandom_range(0, 400000)) - 200000);
         step((k % 4 == 0) || (k % 4 == 3), 1'b0, 0, 1'b0, 1'b0);
      end
      idle(3);

      // Overflow: ch0 A=1.0, x0=2^22 every cycle; clear coincident with set.
      words = '{16384, 0, 0, 0, 0, 0, 0, 0};
      load_words(NW);
      step(1'b0, 1'b0, 0, 1'b1, 1'b0);
      set_x(longint'(1) <<< 22, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0, (i == 5));
      set_x(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0, 1'b1);
      idle(2);

      // Async reset mid-stream with nonzero state and flags.
      set_x(longint'(1) <<< 22, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_y0", longint'(y0_o), 0);
      check("arst_y1", longint'(y1_o), 0);
      check("arst_valid", longint'(out_valid_o), 0);
      check("arst_ovf", longint'(ovf_o), 0);
      check("arst_ptr", longint'(coeff_ptr_o), 0);
      model_reset();
      in_valid_i = 1'b0; coeff_wr_i = 1'b0; coeff_update_i = 1'b0; ovf_clr_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      // Active bank must be zero again: outputs equal inputs.
      for (int i = 0; i < 3; i++) begin
         set_x(1111 * (i + 1), -2222, 333, 4444 - i);
         step(1'b1, 1'b0, 0, 1'b0, 1'b0);
      end

      // Drain the scoreboard within a bounded number of cycles.
      set_x(0, 0, 0, 0);
      for (int i = 0; i < 10 && sb.size() > 0; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
      check("sb_drained", longint'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_biquad_pole_iir_mc
`default_nettype wire
